program_loader: RTL and testbench

//  Upstream feeder for the CPU's 16x8 program memory. Accepts program bytes on a valid/ready

---
 rtl/program_loader.sv | 153 +++++++++++++++
 tb/tb_program_loader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Streams program bytes into a 16x8 program memory from address 0, holding the CPU off the bus.
// Define LOADER_VERIFY_EN to add a read-back VERIFY cycle after every write (ERROR on mismatch).
module program_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  input  logic              i_last,
  output logic              o_ready,
  output logic [ADDR_W-1:0] o_address,
  inout  wire  [DATA_W-1:0] io_bus,
  output logic              o_write_n,
  output logic              o_read_n,
  output logic              o_cpu_hold,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [ADDR_W:0]   o_count
);

  // state | meaning
  // IDLE      | bus released, CPU free, waiting for i_start
  // WAIT_BYTE | o_ready high, waiting for a stream byte
  // WRITE     | one-cycle write strobe, captured byte on io_bus
  // VERIFY    | one-cycle read strobe, read-back compared (verify build only)
  // DONE      | session complete, o_done set
  // ERROR     | read-back mismatch, o_error set (verify build only)
  typedef enum logic [2:0] {IDLE, WAIT_BYTE, WRITE, VERIFY, DONE, ERROR} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state;
  logic [DATA_W-1:0] data_q;
  logic              last_q;
  logic              drive_en;
  logic              end_of_session;

  // Bus is only ever driven during the single WRITE cycle.
  assign io_bus = drive_en ? data_q : 'z;
  assign end_of_session = last_q || (o_address == LAST_ADDR);

`ifdef LOADER_VERIFY_EN
  logic read_n_q;
  logic error_q;
  assign o_read_n = read_n_q;
  assign o_error  = error_q;
`else
  assign o_read_n = 1'b1;
  assign o_error  = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      data_q     <= '0;
      last_q     <= 1'b0;
      drive_en   <= 1'b0;
      o_ready    <= 1'b0;
      o_address  <= '0;
      o_write_n  <= 1'b1;
      o_cpu_hold <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_count    <= '0;
`ifdef LOADER_VERIFY_EN
      read_n_q   <= 1'b1;
      error_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            state      <= WAIT_BYTE;
            o_address  <= '0;
            o_count    <= '0;
            o_done     <= 1'b0;
            o_ready    <= 1'b1;
            o_busy     <= 1'b1;
            o_cpu_hold <= 1'b1;
`ifdef LOADER_VERIFY_EN
            error_q    <= 1'b0;
`endif
          end
        end
        WAIT_BYTE: begin
          if (i_valid) begin
            data_q    <= i_data;
            last_q    <= i_last;
            o_ready   <= 1'b0;
            o_write_n <= 1'b0;
            drive_en  <= 1'b1;
            state     <= WRITE;
          end
        end
`ifdef LOADER_VERIFY_EN
        WRITE: begin
          o_write_n <= 1'b1;
          drive_en  <= 1'b0;
          o_count   <= o_count + 1'b1;
          read_n_q  <= 1'b0;
          state     <= VERIFY;
        end
        VERIFY: begin
          read_n_q <= 1'b1;
          if (io_bus != data_q) begin
            error_q <= 1'b1;
            state   <= ERROR;
          end else if (end_of_session) begin
            o_done <= 1'b1;
            state  <= DONE;
          end else begin
            o_address <= o_address + 1'b1;
            o_ready   <= 1'b1;
            state     <= WAIT_BYTE;
          end
        end
`else
        WRITE: begin
          o_write_n <= 1'b1;
          drive_en  <= 1'b0;
          o_count   <= o_count + 1'b1;
          if (end_of_session) begin
            o_done <= 1'b1;
            state  <= DONE;
          end else begin
            o_address <= o_address + 1'b1;
            o_ready   <= 1'b1;
            state     <= WAIT_BYTE;
          end
        end
`endif
        DONE, ERROR: begin
          o_busy     <= 1'b0;
          o_cpu_hold <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          o_ready    <= 1'b0;
          o_write_n  <= 1'b1;
          drive_en   <= 1'b0;
          o_busy     <= 1'b0;
          o_cpu_hold <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a 16x8 memory model on the shared bus.
// Expectations follow the LOADER_VERIFY_EN setting used for the build.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_start;
  logic [7:0] i_data;
  logic       i_valid;
  logic       i_last;
  logic       o_ready;
  logic [3:0] o_address;
  wire  [7:0] io_bus;
  logic       o_write_n;
  logic       o_read_n;
  logic       o_cpu_hold;
  logic       o_busy;
  logic       o_done;
  logic       o_error;
  logic [4:0] o_count;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [16];
  logic [7:0] exp_mem [16];
  logic       corrupt_en = 1'b0;

  always #5 clk = ~clk;

  program_loader #(.ADDR_W(4), .DATA_W(8)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_data(i_data),
    .i_valid(i_valid), .i_last(i_last), .o_ready(o_ready), .o_address(o_address),
    .io_bus(io_bus), .o_write_n(o_write_n), .o_read_n(o_read_n),
    .o_cpu_hold(o_cpu_hold), .o_busy(o_busy), .o_done(o_done),
    .o_error(o_error), .o_count(o_count)
  );

  // Memory model: a write during reset is treated as aborted; addr 2 can be corrupted on demand.
  always @(posedge clk)
    if (!i_reset && !o_write_n)
      mem[o_address] <= (corrupt_en && o_address == 4'd2) ? (io_bus ^ 8'h01) : io_bus;

  assign io_bus = !o_read_n ? mem[o_address] : 8'bz;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, o_ready, 0);
    chk({tag, "_addr"}, o_address, 0);
    chk({tag, "_write_n"}, o_write_n, 1);
    chk({tag, "_read_n"}, o_read_n, 1);
    chk({tag, "_hold"}, o_cpu_hold, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_error"}, o_error, 0);
    chk({tag, "_count"}, o_count, 0);
  endtask

  task automatic do_start;
    i_start = 1'b1;
    tick;
    i_start = 1'b0;
    chk("start_busy", o_busy, 1);
    chk("start_hold", o_cpu_hold, 1);
    chk("start_ready", o_ready, 1);
    chk("start_count", o_count, 0);
  endtask

  task automatic capture_byte(input logic [7:0] d, input logic l, input logic [3:0] a);
    int n;
    n = 0;
    i_data = d;
    i_last = l;
    i_valid = 1'b1;
    while (!o_ready && n < 20) begin
      tick;
      n++;
    end
    chk("ready_timeout", n < 20, 1);
    tick;
    i_valid = 1'b0;
    i_last = 1'b0;
    chk("wr_strobe", o_write_n, 0);
    chk("wr_addr", o_address, a);
    chk("wr_ready", o_ready, 0);
    chk("wr_bus", io_bus, d);
  endtask

  task automatic finish_write;
    tick;
    chk("wr_pulse_1cyc", o_write_n, 1);
`ifdef LOADER_VERIFY_EN
    chk("rd_strobe", o_read_n, 0);
    tick;
    chk("rd_pulse_1cyc", o_read_n, 1);
`endif
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l, input logic [3:0] a);
    capture_byte(d, l, a);
    exp_mem[a] = d;
    finish_write;
  endtask

  task automatic compare_mem(input string tag);
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s_mem%0d", tag, i), mem[i], exp_mem[i]);
  endtask

  task automatic finish_done(input string tag, input int cnt);
    chk({tag, "_done_state"}, o_done, 1);
    chk({tag, "_busy_in_done"}, o_busy, 1);
    tick;
    chk({tag, "_busy_idle"}, o_busy, 0);
    chk({tag, "_hold_idle"}, o_cpu_hold, 0);
    chk({tag, "_count"}, o_count, cnt);
    chk({tag, "_done_sticky"}, o_done, 1);
    chk({tag, "_error"}, o_error, 0);
  endtask

  task automatic offer_unaccepted(input string tag);
    logic saw;
    saw = 1'b0;
    i_data = 8'hEE;
    i_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      saw = saw | o_ready;
      tick;
    end
    i_valid = 1'b0;
    chk(tag, saw, 0);
  endtask

  logic [7:0] prog1 [7];

  initial begin
    prog1 = '{8'h1D, 8'h61, 8'h40, 8'h90, 8'hC2, 8'h40, 8'hF0};
    for (int i = 0; i < 16; i++) begin
      mem[i] = 8'hA0 + 8'(i);
      exp_mem[i] = 8'hA0 + 8'(i);
    end
    i_reset = 1'b1;
    i_start = 1'b0;
    i_data = 8'h00;
    i_valid = 1'b0;
    i_last = 1'b0;
    tick;
    tick;
    i_reset = 1'b0;
    chk_reset_outputs("por");

    // 1: seven-byte program with i_last on the final byte
    do_start;
    for (int i = 0; i < 7; i++) send_byte(prog1[i], i == 6, 4'(i));
    finish_done("t1", 7);
    compare_mem("t1");

    // 2: sixteen bytes without i_last; address 15 ends the session
    do_start;
    chk("t2_done_cleared", o_done, 0);
    for (int i = 0; i < 16; i++) send_byte(8'h30 + 8'(i), 1'b0, 4'(i));
    finish_done("t2", 16);
    offer_unaccepted("t2_no_17th");
    compare_mem("t2");

    // 3: random gaps between bytes; ready must stay high while waiting
    do_start;
    for (int i = 0; i < 5; i++) begin
      int gap;
      gap = int'($urandom_range(0, 5));
      for (int g = 0; g < gap; g++) begin
        chk("t3_gap_ready", o_ready, 1);
        chk("t3_gap_write_n", o_write_n, 1);
        tick;
      end
      send_byte(8'hC0 + 8'(i), i == 4, 4'(i));
    end
    finish_done("t3", 5);
    compare_mem("t3");

    // 4: reset during the write of byte 3
    do_start;
    send_byte(8'h11, 1'b0, 4'd0);
    send_byte(8'h22, 1'b0, 4'd1);
    capture_byte(8'h33, 1'b0, 4'd2);
    i_reset = 1'b1;
    tick;
    i_reset = 1'b0;
    chk_reset_outputs("t4_abort");
    compare_mem("t4_abort");
    do_start;
    send_byte(8'h44, 1'b0, 4'd0);
    send_byte(8'h55, 1'b0, 4'd1);
    send_byte(8'h66, 1'b1, 4'd2);
    finish_done("t4_reload", 3);
    compare_mem("t4_reload");

    // 5: i_start while busy is ignored
    do_start;
    send_byte(8'h71, 1'b0, 4'd0);
    capture_byte(8'h72, 1'b0, 4'd1);
    exp_mem[1] = 8'h72;
    i_start = 1'b1;
    finish_write;
    chk("t5_count_mid", o_count, 2);
    chk("t5_busy_mid", o_busy, 1);
    send_byte(8'h73, 1'b1, 4'd2);
    i_start = 1'b0;
    finish_done("t5", 3);
    compare_mem("t5");

    // 6: memory corrupts address 2
    corrupt_en = 1'b1;
    do_start;
    send_byte(8'h81, 1'b0, 4'd0);
    send_byte(8'h82, 1'b0, 4'd1);
`ifdef LOADER_VERIFY_EN
    capture_byte(8'h83, 1'b0, 4'd2);
    exp_mem[2] = 8'h82;
    tick;
    chk("t6_verify_rd", o_read_n, 0);
    tick;
    chk("t6_error_set", o_error, 1);
    chk("t6_error_done", o_done, 0);
    tick;
    chk("t6_idle_busy", o_busy, 0);
    chk("t6_idle_error", o_error, 1);
    chk("t6_idle_done", o_done, 0);
    chk("t6_count", o_count, 3);
    offer_unaccepted("t6_no_accept");
`else
    send_byte(8'h83, 1'b0, 4'd2);
    exp_mem[2] = 8'h82;
    send_byte(8'h84, 1'b1, 4'd3);
    finish_done("t6", 4);
`endif
    corrupt_en = 1'b0;
    compare_mem("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
